// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the IF-stage PC generator: next-PC select codes,
// fetch FSM states and the default reset PC (word address of byte 0x0000_3000).
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } fetch_state_e;

    localparam logic [29:0] DEFAULT_RESET_PC = 30'h0000_0C00;

    function automatic logic [29:0] sext30(input logic [15:0] v);
        return {{14{v[15]}}, v};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Purely combinational redirect decode and target computation (word units, wrapping).
// Also used by the ID-stage branch predictor check.
module npc_calc
    import pc_fetch_pkg::*;
(
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [29:0] id_pc4,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    output logic        redir,
    output logic [29:0] target,
    output logic        jr_bad
);

    always_comb begin
        redir  = 1'b0;
        target = '0;
        case (npc_op)
            NPC_BR: begin
                redir  = br_taken;
                target = id_pc4 + sext30(imm16);
            end
            NPC_J: begin
                redir  = 1'b1;
                target = {id_pc4[29:26], instr_index};
            end
            NPC_JR: begin
                redir  = 1'b1;
                target = rs_data[31:2];
            end
            default: begin
                redir  = 1'b0;
                target = '0;
            end
        endcase
    end

    // A JR with a non-word-aligned register value still redirects; it is only flagged.
    assign jr_bad = (npc_op == NPC_JR) && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch.sv
// IF-stage PC register with a one-entry pending-redirect buffer, so a redirect
// arriving during a stall is replayed when PCWr returns. redir_pend mirrors the FSM state.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [29:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWr,
    input  logic [1:0]  NPCOp,
    input  logic        br_taken,
    input  logic [29:0] id_PC4,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    output logic [29:0] PC,
    output logic        flush,
    output logic        redir_pend,
    output logic        jr_misalign,
    output logic [31:0] fetch_cnt
);

    logic         redir;
    logic [29:0]  target;
    logic         jr_bad;

    fetch_state_e state_q, state_d;
    logic [29:0]  pc_q, pc_d;
    logic [29:0]  pend_pc_q, pend_pc_d;
    logic         jr_misalign_q, jr_misalign_d;
    logic [31:0]  fetch_cnt_q, fetch_cnt_d;
    logic         flush_c;

    npc_calc u_npc_calc (
        .npc_op      (NPCOp),
        .br_taken    (br_taken),
        .id_pc4      (id_PC4),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .redir       (redir),
        .target      (target),
        .jr_bad      (jr_bad)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        fetch_cnt_d   = fetch_cnt_q;
        jr_misalign_d = jr_bad;
        flush_c       = 1'b0;
        if (PCWr) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
            state_d     = ST_RUN;
            flush_c     = !DELAY_SLOT && (redir || (state_q == ST_PEND));
            // A live redirect is younger than the buffered one, so it wins.
            if (redir) begin
                pc_d = target;
            end else if (state_q == ST_PEND) begin
                pc_d = pend_pc_q;
            end else begin
                pc_d = pc_q + 30'd1;
            end
        end else if (redir) begin
            pend_pc_d = target;
            state_d   = ST_PEND;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            pend_pc_q     <= '0;
            jr_misalign_q <= 1'b0;
            fetch_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            jr_misalign_q <= jr_misalign_d;
            fetch_cnt_q   <= fetch_cnt_d;
        end
    end

    assign PC          = pc_q;
    assign flush       = flush_c;
    assign redir_pend  = (state_q == ST_PEND);
    assign jr_misalign = jr_misalign_q;
    assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus a random run against a small
// behavioural model; a delay-slot and a flushing instance share the stimulus.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic        PCWr;
    logic [1:0]  NPCOp;
    logic        br_taken;
    logic [29:0] id_PC4;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data;

    logic [29:0] pc_a, pc_b;
    logic        flush_a, flush_b;
    logic        pend_a, pend_b;
    logic        mis_a, mis_b;
    logic [31:0] cnt_a, cnt_b;

    logic [29:0] exp_q[$];
    logic [29:0] exp_pc;
    int checks;
    int failures;

    // random-run model state
    logic [29:0] m_pc, m_pend_pc;
    logic        m_pend;
    logic [31:0] m_cnt;

    pc_fetch #(.DELAY_SLOT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .PCWr(PCWr), .NPCOp(NPCOp), .br_taken(br_taken),
        .id_PC4(id_PC4), .imm16(imm16), .instr_index(instr_index), .rs_data(rs_data),
        .PC(pc_a), .flush(flush_a), .redir_pend(pend_a), .jr_misalign(mis_a),
        .fetch_cnt(cnt_a)
    );

    pc_fetch #(.DELAY_SLOT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .PCWr(PCWr), .NPCOp(NPCOp), .br_taken(br_taken),
        .id_PC4(id_PC4), .imm16(imm16), .instr_index(instr_index), .rs_data(rs_data),
        .PC(pc_b), .flush(flush_b), .redir_pend(pend_b), .jr_misalign(mis_b),
        .fetch_cnt(cnt_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic drive(input logic pcwr, input logic [1:0] op, input logic taken,
                         input logic [29:0] pc4, input logic [15:0] imm,
                         input logic [25:0] idx, input logic [31:0] rs);
        PCWr = pcwr; NPCOp = op; br_taken = taken;
        id_PC4 = pc4; imm16 = imm; instr_index = idx; rs_data = rs;
    endtask

    task automatic idle(input logic pcwr);
        drive(pcwr, 2'b00, 1'b0, 30'h0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++;
        if (pc_a !== 30'h0000_0C00 || pend_a !== 1'b0 || mis_a !== 1'b0 || cnt_a !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: pc=%h pend=%b mis=%b cnt=%0d, want pc=c00 pend=0 mis=0 cnt=0",
                     pc_a, pend_a, mis_a, cnt_a);
        end
    endtask

    task automatic test_seq;
        for (int i = 1; i <= 4; i++) begin
            idle(1'b1);
            exp_q.push_back(30'h0000_0C00 + 30'(i));
            tick;
            exp_pc = exp_q.pop_front();
            checks++;
            if (pc_a !== exp_pc) begin
                failures++;
                $display("FAIL seq_pc: step %0d pc=%h want %h", i, pc_a, exp_pc);
            end
        end
        checks++;
        if (cnt_a !== 32'd4) begin
            failures++;
            $display("FAIL seq_cnt: cnt=%0d want 4", cnt_a);
        end
    endtask

    task automatic test_branch;
        drive(1'b1, 2'b01, 1'b1, 30'h0000_0C05, 16'hFFFC, 26'h0, 32'h0);
        exp_q.push_back(30'h0000_0C01);
        #1;
        checks++;
        if (flush_a !== 1'b0 || flush_b !== 1'b1) begin
            failures++;
            $display("FAIL br_flush: ds1=%b ds0=%b want ds1=0 ds0=1", flush_a, flush_b);
        end
        tick;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc_a !== exp_pc || pc_b !== exp_pc) begin
            failures++;
            $display("FAIL br_target: pc_a=%h pc_b=%h want %h", pc_a, pc_b, exp_pc);
        end
    endtask

    task automatic test_jump;
        drive(1'b1, 2'b10, 1'b0, 30'h3000_0010, 16'h0, 26'h000_0100, 32'h0);
        exp_q.push_back(30'h3000_0100);
        tick;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc_a !== exp_pc) begin
            failures++;
            $display("FAIL j_target: pc=%h want %h", pc_a, exp_pc);
        end
        drive(1'b1, 2'b11, 1'b0, 30'h0, 16'h0, 26'h0, 32'h0000_3013);
        exp_q.push_back(30'h0000_0C04);
        tick;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc_a !== exp_pc || mis_a !== 1'b1) begin
            failures++;
            $display("FAIL jr_target: pc=%h mis=%b want pc=%h mis=1", pc_a, mis_a, exp_pc);
        end
        idle(1'b1);
        exp_q.push_back(30'h0000_0C05);
        tick;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc_a !== exp_pc || mis_a !== 1'b0 || cnt_a !== 32'd8) begin
            failures++;
            $display("FAIL jr_pulse: pc=%h mis=%b cnt=%0d want pc=%h mis=0 cnt=8",
                     pc_a, mis_a, cnt_a, exp_pc);
        end
    endtask

    task automatic test_stall_pend;
        drive(1'b0, 2'b10, 1'b0, 30'h0, 16'h0, 26'h40, 32'h0);
        #1;
        checks++;
        if (flush_b !== 1'b0) begin
            failures++;
            $display("FAIL stall_flush: ds0=%b want 0", flush_b);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(30'h0000_0C05);
            tick;
            idle(1'b0);
            exp_pc = exp_q.pop_front();
            checks++;
            if (pc_a !== exp_pc || pend_a !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold: cyc %0d pc=%h pend=%b want pc=%h pend=1",
                         i, pc_a, pend_a, exp_pc);
            end
        end
        idle(1'b1);
        #1;
        checks++;
        if (flush_a !== 1'b0 || flush_b !== 1'b1) begin
            failures++;
            $display("FAIL pend_flush: ds1=%b ds0=%b want ds1=0 ds0=1", flush_a, flush_b);
        end
        exp_q.push_back(30'h0000_0040);
        tick;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc_a !== exp_pc || pend_a !== 1'b0 || cnt_a !== 32'd9) begin
            failures++;
            $display("FAIL pend_replay: pc=%h pend=%b cnt=%0d want pc=%h pend=0 cnt=9",
                     pc_a, pend_a, cnt_a, exp_pc);
        end
    endtask

    task automatic test_pend_override;
        // latest buffered redirect wins over the older one
        drive(1'b0, 2'b10, 1'b0, 30'h0, 16'h0, 26'h40, 32'h0);
        tick;
        drive(1'b0, 2'b10, 1'b0, 30'h0, 16'h0, 26'h50, 32'h0);
        tick;
        idle(1'b1);
        exp_q.push_back(30'h0000_0050);
        tick;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc_a !== exp_pc) begin
            failures++;
            $display("FAIL pend_latest: pc=%h want %h", pc_a, exp_pc);
        end
        // live redirect beats the buffered one
        drive(1'b0, 2'b10, 1'b0, 30'h0, 16'h0, 26'h40, 32'h0);
        tick;
        drive(1'b1, 2'b11, 1'b0, 30'h0, 16'h0, 26'h0, 32'h0000_0200);
        exp_q.push_back(30'h0000_0080);
        tick;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc_a !== exp_pc || pend_a !== 1'b0 || mis_a !== 1'b0 || cnt_a !== 32'd11) begin
            failures++;
            $display("FAIL pend_younger: pc=%h pend=%b mis=%b cnt=%0d want pc=%h pend=0 mis=0 cnt=11",
                     pc_a, pend_a, mis_a, cnt_a, exp_pc);
        end
    endtask

    task automatic test_wrap_and_reset;
        drive(1'b1, 2'b11, 1'b0, 30'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        tick;
        drive(1'b1, 2'b01, 1'b0, 30'h0000_1234, 16'h0100, 26'h0, 32'h0);
        exp_q.push_back(30'h0000_0000);
        tick;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc_a !== exp_pc || cnt_a !== 32'd13) begin
            failures++;
            $display("FAIL wrap_pc: pc=%h cnt=%0d want pc=%h cnt=13", pc_a, cnt_a, exp_pc);
        end
        drive(1'b0, 2'b10, 1'b0, 30'h0, 16'h0, 26'h77, 32'h0);
        tick;
        idle(1'b0);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (pc_a !== 30'h0000_0C00 || pend_a !== 1'b0 || cnt_a !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: pc=%h pend=%b cnt=%0d want pc=c00 pend=0 cnt=0",
                     pc_a, pend_a, cnt_a);
        end
        #2 rst = 1'b1;
        idle(1'b1);
        exp_q.push_back(30'h0000_0C01);
        tick;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc_a !== exp_pc || pend_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_restart: pc=%h pend=%b want pc=%h pend=0", pc_a, pend_a, exp_pc);
        end
    endtask

    task automatic test_random;
        logic        pcwr, taken, redir, mis, exp_flush;
        logic [1:0]  op;
        logic [29:0] pc4, tgt;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;
        m_pc = 30'h0000_0C01; m_pend = 1'b0; m_pend_pc = '0; m_cnt = 32'd1;
        for (int n = 0; n < 300; n++) begin
            pcwr  = ($urandom_range(0, 3) != 0);
            op    = 2'($urandom_range(0, 3));
            taken = 1'($urandom_range(0, 1));
            pc4   = 30'($urandom());
            imm   = 16'($urandom());
            idx   = 26'($urandom());
            rs    = $urandom();
            drive(pcwr, op, taken, pc4, imm, idx, rs);
            redir = (op == 2'b01 && taken) || op == 2'b10 || op == 2'b11;
            if (op == 2'b01)      tgt = pc4 + {{14{imm[15]}}, imm};
            else if (op == 2'b10) tgt = {pc4[29:26], idx};
            else                  tgt = rs[31:2];
            mis = (op == 2'b11) && (rs[1:0] != 2'b00);
            exp_flush = pcwr && (redir || m_pend);
            if (pcwr) begin
                m_cnt = m_cnt + 32'd1;
                m_pc  = redir ? tgt : (m_pend ? m_pend_pc : m_pc + 30'd1);
                m_pend = 1'b0;
            end else if (redir) begin
                m_pend_pc = tgt;
                m_pend = 1'b1;
            end
            exp_q.push_back(m_pc);
            #1;
            checks++;
            if (flush_a !== 1'b0 || flush_b !== exp_flush) begin
                failures++;
                $display("FAIL rand_flush: n=%0d ds1=%b ds0=%b want ds1=0 ds0=%b",
                         n, flush_a, flush_b, exp_flush);
            end
            tick;
            exp_pc = exp_q.pop_front();
            checks++;
            if (pc_a !== exp_pc || pc_b !== exp_pc || pend_a !== m_pend ||
                cnt_a !== m_cnt || mis_a !== mis || pend_b !== m_pend || cnt_b !== m_cnt) begin
                failures++;
                $display("FAIL rand_state: n=%0d pc=%h/%h pend=%b cnt=%0d mis=%b want pc=%h pend=%b cnt=%0d mis=%b",
                         n, pc_a, pc_b, pend_a, cnt_a, mis_a, exp_pc, m_pend, m_cnt, mis);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        idle(1'b1);
        #12;
        test_reset;
        rst = 1'b1;
        test_seq;
        test_branch;
        test_jump;
        test_stall_pend;
        test_pend_override;
        test_wrap_and_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
